audio_stream_sequencer: RTL and testbench

AUDIO_STREAM_SEQUENCER -- requirements
Module: audio_stream_sequencer

---
 rtl/audio_stream_sequencer.sv | 115 +++++++++++
 tb/tb_audio_stream_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_sequencer.sv
// Audio stream sequencer: pulls 32-bit words from the HPS FIFO and plays each
// 24-bit sample to the codec as an L/R pair, with an underrun counter and a level meter.
module audio_stream_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mute,
  input  logic        clr_underrun,
  input  logic [31:0] fifo_data,
  input  logic        fifo_valid,
  output logic        fifo_ready,
  input  logic        audio_ready_l,
  input  logic        audio_ready_r,
  output logic        audio_valid_l,
  output logic        audio_valid_r,
  output logic [23:0] audio_data_l,
  output logic [23:0] audio_data_r,
  output logic [15:0] underrun_count,
  output logic [9:0]  leds,
  output logic        busy
);

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LED_N    = 10;
  localparam int unsigned LEVEL_W  = 4;

  typedef enum logic [1:0] {IDLE, FETCH, SEND_L, SEND_R} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                capture_c;
  logic [SAMPLE_W-1:0] hold;
  logic [SAMPLE_W-1:0] raw_c;
  logic [SAMPLE_W-1:0] mag_c;
  logic [LEVEL_W-1:0]  level_c;
  logic [LED_N-1:0]    leds_nxt_c;
  logic                unused_lsbs_c;

  assign raw_c         = fifo_data[31:8];
  assign unused_lsbs_c = ^fifo_data[7:0];

  // Next-state logic; a capture happens only in FETCH with a word offered
  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    case (state)
      IDLE:   if (enable) state_nxt = FETCH;
      FETCH: begin
        if (fifo_valid) begin
          capture_c = 1'b1;
          state_nxt = SEND_L;
        end else if (!enable) begin
          state_nxt = IDLE;
        end
      end
      SEND_L: if (audio_ready_l) state_nxt = SEND_R;
      SEND_R: if (audio_ready_r) state_nxt = enable ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Meter works on the raw sample so it still moves while muted
  always_comb begin
    mag_c   = raw_c[SAMPLE_W-1] ? ~raw_c : raw_c;
    level_c = mag_c[22:19];
    leds_nxt_c = '0;
    for (int i = 0; i < int'(LED_N); i++) begin
      leds_nxt_c[i] = (level_c > LEVEL_W'(i));
    end
  end

  // State plus Moore outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      fifo_ready    <= 1'b0;
      audio_valid_l <= 1'b0;
      audio_valid_r <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      fifo_ready    <= (state_nxt == FETCH);
      audio_valid_l <= (state_nxt == SEND_L);
      audio_valid_r <= (state_nxt == SEND_R);
      busy          <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
      leds <= '0;
    end else if (capture_c) begin
      hold <= mute ? '0 : raw_c;
      leds <= leds_nxt_c;
    end
  end

  // Starvation counter; clear has priority and the count saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (clr_underrun) begin
      underrun_count <= '0;
    end else if (state == FETCH && enable && !fifo_valid &&
                 underrun_count != {CNT_W{1'b1}}) begin
      underrun_count <= underrun_count + CNT_W'(1);
    end
  end

  assign audio_data_l = hold;
  assign audio_data_r = hold;

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Bench for audio_stream_sequencer: directed scenarios plus random traffic,
// all checked against a phase-level behavioural model.
module tb_audio_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, mute, clr_underrun;
  logic [31:0] fifo_data;
  logic        fifo_valid, fifo_ready;
  logic        audio_ready_l, audio_ready_r;
  logic        audio_valid_l, audio_valid_r;
  logic [23:0] audio_data_l, audio_data_r;
  logic [15:0] underrun_count;
  logic [9:0]  leds;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: which of the four spec phases we are in, plus visible registers
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_LEFT = 2, PH_RIGHT = 3;
  int          m_ph;
  logic [23:0] m_hold;
  logic [9:0]  m_leds;
  int          m_und;
  logic [23:0] saved;

  audio_stream_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .mute(mute),
    .clr_underrun(clr_underrun), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_ready(fifo_ready), .audio_ready_l(audio_ready_l), .audio_ready_r(audio_ready_r),
    .audio_valid_l(audio_valid_l), .audio_valid_r(audio_valid_r),
    .audio_data_l(audio_data_l), .audio_data_r(audio_data_r),
    .underrun_count(underrun_count), .leds(leds), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] meter(input logic [23:0] s);
    logic [23:0] mag;
    int lvl;
    mag = s[23] ? ~s : s;
    lvl = int'(mag[22:19]);
    if (lvl > 10) lvl = 10;
    return 10'((1 << lvl) - 1);
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_hold = '0; m_leds = '0; m_und = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (clr_underrun) m_und = 0;
    else if (m_ph == PH_FETCH && enable && !fifo_valid && m_und < 65535) m_und++;
    case (m_ph)
      PH_IDLE:  if (enable) m_ph = PH_FETCH;
      PH_FETCH: begin
        if (fifo_valid) begin
          m_hold = mute ? 24'h0 : fifo_data[31:8];
          m_leds = meter(fifo_data[31:8]);
          m_ph   = PH_LEFT;
        end else if (!enable) m_ph = PH_IDLE;
      end
      PH_LEFT:  if (audio_ready_l) m_ph = PH_RIGHT;
      default:  if (audio_ready_r) m_ph = enable ? PH_FETCH : PH_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("fifo_ready", 32'(fifo_ready), 32'(m_ph == PH_FETCH));
    chk("valid_l",    32'(audio_valid_l), 32'(m_ph == PH_LEFT));
    chk("valid_r",    32'(audio_valid_r), 32'(m_ph == PH_RIGHT));
    chk("busy",       32'(busy), 32'(m_ph != PH_IDLE));
    chk("data_l",     32'(audio_data_l), 32'(m_hold));
    chk("data_r",     32'(audio_data_r), 32'(m_hold));
    chk("leds",       32'(leds), 32'(m_leds));
    chk("underrun",   32'(underrun_count), 32'(m_und));
  endtask

  task automatic tick(input bit do_chk = 1'b1);
    model_edge();
    @(posedge clk);
    #1;
    if (do_chk) check_all();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; mute = 1'b0; clr_underrun = 1'b0;
    fifo_data = '0; fifo_valid = 1'b0; audio_ready_l = 1'b0; audio_ready_r = 1'b0;
    model_reset();

    // Reset state
    #2 reset = 1'b1;
    #1 check_all();
    tick(); tick();
    reset = 1'b0;

    // Basic pair with both readies high
    enable = 1'b1; fifo_valid = 1'b1; fifo_data = 32'h123456AB;
    audio_ready_l = 1'b1; audio_ready_r = 1'b1;
    tick();
    chk("a_fetch", 32'(fifo_ready), 32'd1);
    tick();
    fifo_valid = 1'b0;
    chk("a_valid_l", 32'(audio_valid_l), 32'd1);
    chk("a_data_l",  32'(audio_data_l), 32'h123456);
    chk("a_leds",    32'(leds), 32'h003);
    tick();
    chk("a_valid_r", 32'(audio_valid_r), 32'd1);
    chk("a_data_r",  32'(audio_data_r), 32'h123456);
    tick();
    chk("a_ready_back", 32'(fifo_ready), 32'd1);

    // Most negative sample
    fifo_valid = 1'b1; fifo_data = 32'h80000000;
    tick();
    fifo_valid = 1'b0;
    chk("b_data_l", 32'(audio_data_l), 32'h800000);
    chk("b_leds",   32'(leds), 32'h3FF);
    tick();
    chk("b_data_r", 32'(audio_data_r), 32'h800000);
    tick();

    // Codec left side back-pressure for 5 cycles
    fifo_valid = 1'b1; fifo_data = $urandom; audio_ready_l = 1'b0;
    tick();
    fifo_valid = 1'b1;
    saved = audio_data_l;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c_hold_valid", 32'(audio_valid_l), 32'd1);
      chk("c_stable",     32'(audio_data_l), 32'(saved));
      chk("c_no_fetch",   32'(fifo_ready), 32'd0);
    end
    fifo_valid = 1'b0; audio_ready_l = 1'b1;
    tick();
    chk("c_valid_r", 32'(audio_valid_r), 32'd1);
    tick();

    // Underrun counting, clear priority and saturation
    clr_underrun = 1'b1;
    tick();
    chk("d_clr_pri", 32'(underrun_count), 32'd0);
    clr_underrun = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("d_count20", 32'(underrun_count), 32'd20);
    clr_underrun = 1'b1;
    tick();
    chk("d_clear", 32'(underrun_count), 32'd0);
    clr_underrun = 1'b0;
    for (int i = 0; i < 70000; i++) tick(1'b0);
    check_all();
    chk("d_sat", 32'(underrun_count), 32'hFFFF);

    // Mute at capture, then toggled while the pair is in flight
    mute = 1'b1; fifo_valid = 1'b1; fifo_data = 32'h7FFFFF00; audio_ready_l = 1'b0;
    tick();
    fifo_valid = 1'b0; mute = 1'b0;
    chk("e_data_l", 32'(audio_data_l), 32'h0);
    chk("e_leds",   32'(leds), 32'h3FF);
    tick();
    chk("e_toggle0", 32'(audio_data_l), 32'h0);
    mute = 1'b1;
    tick();
    chk("e_toggle1", 32'(audio_data_l), 32'h0);
    mute = 1'b0; audio_ready_l = 1'b1;
    tick();
    chk("e_data_r", 32'(audio_data_r), 32'h0);
    tick();

    // Reset while the right sample is waiting
    fifo_valid = 1'b1; fifo_data = 32'hF0000000 | $urandom; audio_ready_r = 1'b0;
    tick();
    fifo_valid = 1'b0;
    tick();
    chk("f_in_right", 32'(audio_valid_r), 32'd1);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("f_valid_r0", 32'(audio_valid_r), 32'd0);
    chk("f_busy0",    32'(busy), 32'd0);
    chk("f_leds0",    32'(leds), 32'd0);
    chk("f_und0",     32'(underrun_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; audio_ready_r = 1'b1; enable = 1'b1;
    tick();
    chk("f_refetch", 32'(fifo_ready), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      fifo_valid    = 1'($urandom_range(0, 1));
      fifo_data     = $urandom;
      mute          = ($urandom_range(0, 3) == 0);
      audio_ready_l = ($urandom_range(0, 9) < 7);
      audio_ready_r = ($urandom_range(0, 9) < 7);
      clr_underrun  = ($urandom_range(0, 40) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
